// File: rtl/bus_arbiter_n_pkg.sv
// Shared definitions for the N-master valid/ready bus arbiter.
// Contents:
//   state_e  - arbiter state encoding (IDLE=0, BUSY=1)
//   grant_w  - width of a master index, never less than 1 bit
//   strb_w   - byte-strobe width for a given data width
package bus_arbiter_n_pkg;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_BUSY = 1'b1;

  typedef enum logic {
    ST_IDLE = STATE_IDLE,
    ST_BUSY = STATE_BUSY
  } state_e;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/bus_arbiter_n_rr_picker.sv
// Combinational winner selection from a request vector.
// Round-robin mode: the lowest requesting index at or above start_i wins;
// if none exists the search wraps to the lowest requesting index overall.
// Fixed mode (fixed_i=1): the lowest requesting index wins, start_i ignored.
// Ports:
//   req_i   in  N        request vector
//   start_i in  GRANT_W  round-robin start pointer
//   fixed_i in  1        1 = fixed priority
//   idx_o   out GRANT_W  winning index (0 when no request)
//   any_o   out 1        at least one request present
module rr_picker
  import bus_arbiter_n_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]            req_i,
  input  logic [grant_w(N)-1:0]   start_i,
  input  logic                    fixed_i,
  output logic [grant_w(N)-1:0]   idx_o,
  output logic                    any_o
);

  localparam int GW = grant_w(N);

  logic [N-1:0] mask;
  logic [N-1:0] req_hi;
  logic [N-1:0] search;

  always_comb begin
    mask = '0;
    for (int k = 0; k < N; k++) begin
      mask[k] = fixed_i | (GW'(k) >= start_i);
    end
    req_hi = req_i & mask;
    // Upper segment first; fall back to the whole vector to wrap around.
    search = (|req_hi) ? req_hi : req_i;
    idx_o  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (search[k]) idx_o = GW'(k);
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master to 1-slave arbiter for the valid/ready memory bus.
// A winner is chosen in IDLE and locked for the whole transaction in BUSY.
// The transaction ends on s_ready (normal), on the master dropping m_valid
// (abort, no m_ready) or on watchdog expiry (forced m_ready with zero data,
// sticky timeout_err).
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   m_valid/m_ready      per-master request / completion pulse
//   m_addr/m_wdata/m_wstrb  packed per-master request fields
//   m_rdata              shared read data, valid with the m_ready bit
//   s_valid/s_ready      slave handshake
//   s_addr/s_wdata/s_wstrb/s_rdata  slave fields
//   grant_id             current or last granted master
//   timeout_err          sticky watchdog flag
module bus_arbiter_n
  import bus_arbiter_n_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_M-1:0]              m_valid,
  output logic [NUM_M-1:0]              m_ready,
  input  logic [NUM_M*ADDR_W-1:0]       m_addr,
  input  logic [NUM_M*DATA_W-1:0]       m_wdata,
  input  logic [NUM_M*strb_w(DATA_W)-1:0] m_wstrb,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_valid,
  input  logic                          s_ready,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [strb_w(DATA_W)-1:0]     s_wstrb,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic [grant_w(NUM_M)-1:0]     grant_id,
  output logic                          timeout_err
);

  localparam int GW = grant_w(NUM_M);
  localparam int SW = strb_w(DATA_W);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e          state_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   rr_q;
  logic [CW-1:0]   cnt_q;
  logic            terr_q;

  logic [GW-1:0]   pick_idx;
  logic            pick_any;
  logic [GW-1:0]   rr_next;
  logic            busy;
  logic            gvalid;
  logic            expire;
  logic            done_ok;
  logic            done_to;
  logic            abort;

  logic [ADDR_W-1:0] addr_a  [NUM_M];
  logic [DATA_W-1:0] wdata_a [NUM_M];
  logic [SW-1:0]     wstrb_a [NUM_M];

  for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
    assign addr_a[i]  = m_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = m_wdata[i*DATA_W +: DATA_W];
    assign wstrb_a[i] = m_wstrb[i*SW +: SW];
  end

  rr_picker #(
    .N (NUM_M)
  ) u_picker (
    .req_i   (m_valid),
    .start_i (rr_q),
    .fixed_i (RR_EN == 0),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    busy    = (state_q == ST_BUSY);
    gvalid  = m_valid[grant_q];
    expire  = (TIMEOUT > 0) && (cnt_q == CNT_LAST);
    // s_ready on the expiry cycle counts as a normal completion.
    done_ok = busy && gvalid && s_ready;
    done_to = busy && gvalid && !s_ready && expire;
    abort   = busy && !gvalid;
    rr_next = (grant_q == GW'(NUM_M - 1)) ? '0 : grant_q + 1'b1;
  end

  always_comb begin
    s_valid = busy & gvalid;
    s_addr  = busy ? addr_a[grant_q]  : '0;
    s_wdata = busy ? wdata_a[grant_q] : '0;
    s_wstrb = busy ? wstrb_a[grant_q] : '0;
    m_rdata = (busy && !done_to) ? s_rdata : '0;
    m_ready = '0;
    if (done_ok || done_to) m_ready[grant_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (pick_any) begin
            grant_q <= pick_idx;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (done_ok || done_to) begin
            state_q <= ST_IDLE;
            if (RR_EN != 0) rr_q <= rr_next;
            if (done_to) terr_q <= 1'b1;
          end else if (abort) begin
            // Aborts leave the round-robin pointer where it was.
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_id    = grant_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_bus_arbiter_n.sv
module tb_bus_arbiter_n;

  localparam logic [31:0] K = 32'hDEAD_0000;

  typedef struct {
    logic [3:0]  mr;
    logic [31:0] rd;
    logic [1:0]  gid;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        terr;
    int          gap;
  } exp_t;

  typedef struct {
    logic [3:0]  mr;
    logic [31:0] rd;
    logic [1:0]  gid;
  } fexp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Round-robin instance
  logic [3:0]   mv;
  logic [31:0]  ma [4];
  logic [31:0]  wd [4];
  logic [3:0]   ws [4];
  logic         sr;
  logic [3:0]   m_ready;
  logic [31:0]  m_rdata;
  logic         s_valid;
  logic [31:0]  s_addr, s_wdata, s_rdata;
  logic [3:0]   s_wstrb;
  logic [1:0]   grant_id;
  logic         timeout_err;

  assign s_rdata = s_addr ^ K;

  bus_arbiter_n #(.NUM_M(4), .ADDR_W(32), .DATA_W(32), .RR_EN(1), .TIMEOUT(8)) u_rr (
    .clk(clk), .resetn(resetn),
    .m_valid(mv), .m_ready(m_ready),
    .m_addr({ma[3], ma[2], ma[1], ma[0]}),
    .m_wdata({wd[3], wd[2], wd[1], wd[0]}),
    .m_wstrb({ws[3], ws[2], ws[1], ws[0]}),
    .m_rdata(m_rdata),
    .s_valid(s_valid), .s_ready(sr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  // Fixed-priority instance
  logic [3:0]   mvf;
  logic [31:0]  maf [4];
  logic [3:0]   m_ready_f;
  logic [31:0]  m_rdata_f;
  logic         s_valid_f;
  logic [31:0]  s_addr_f, s_wdata_f, s_rdata_f;
  logic [3:0]   s_wstrb_f;
  logic [1:0]   grant_id_f;
  logic         timeout_err_f;

  assign s_rdata_f = s_addr_f ^ K;

  bus_arbiter_n #(.NUM_M(4), .ADDR_W(32), .DATA_W(32), .RR_EN(0), .TIMEOUT(8)) u_fx (
    .clk(clk), .resetn(resetn),
    .m_valid(mvf), .m_ready(m_ready_f),
    .m_addr({maf[3], maf[2], maf[1], maf[0]}),
    .m_wdata(128'h0),
    .m_wstrb(16'h0),
    .m_rdata(m_rdata_f),
    .s_valid(s_valid_f), .s_ready(1'b1), .s_addr(s_addr_f), .s_wdata(s_wdata_f),
    .s_wstrb(s_wstrb_f), .s_rdata(s_rdata_f),
    .grant_id(grant_id_f), .timeout_err(timeout_err_f)
  );

  exp_t  q_rr[$];
  fexp_t q_fx[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_rr(input int g, input logic to, input logic terr, input int gap);
    exp_t e;
    e.mr   = 4'(1 << g);
    e.rd   = to ? 32'h0 : (ma[g] ^ K);
    e.gid  = 2'(g);
    e.addr = ma[g];
    e.wd   = wd[g];
    e.ws   = ws[g];
    e.terr = terr;
    e.gap  = gap;
    q_rr.push_back(e);
  endtask

  task automatic expect_fx(input int g);
    fexp_t e;
    e.mr  = 4'(1 << g);
    e.rd  = maf[g] ^ K;
    e.gid = 2'(g);
    q_fx.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    mv = '0; mvf = '0; sr = 1'b0;
    step(2);
    resetn = 1'b1;
  endtask

  // Monitor: round-robin instance
  always @(negedge clk) begin
    exp_t e;
    if (resetn && m_ready != 4'b0) begin
      if (q_rr.size() == 0) begin
        checks++; errors++;
        $display("FAIL rr_unexpected_ready: got %b expected none", m_ready);
      end else begin
        e = q_rr.pop_front();
        chk("rr_m_ready", 64'(m_ready), 64'(e.mr));
        chk("rr_grant_id", 64'(grant_id), 64'(e.gid));
        chk("rr_m_rdata", 64'(m_rdata), 64'(e.rd));
        chk("rr_s_addr", 64'(s_addr), 64'(e.addr));
        chk("rr_s_wdata", 64'(s_wdata), 64'(e.wd));
        chk("rr_s_wstrb", 64'(s_wstrb), 64'(e.ws));
        chk("rr_timeout_err", 64'(timeout_err), 64'(e.terr));
        if (e.gap != 0) chk("rr_gap", 64'(cyc - last_cyc), 64'(e.gap));
      end
      last_cyc = cyc;
    end
  end

  // Monitor: fixed-priority instance
  always @(negedge clk) begin
    fexp_t e;
    if (resetn && m_ready_f != 4'b0) begin
      if (q_fx.size() == 0) begin
        checks++; errors++;
        $display("FAIL fx_unexpected_ready: got %b expected none", m_ready_f);
      end else begin
        e = q_fx.pop_front();
        chk("fx_m_ready", 64'(m_ready_f), 64'(e.mr));
        chk("fx_grant_id", 64'(grant_id_f), 64'(e.gid));
        chk("fx_m_rdata", 64'(m_rdata_f), 64'(e.rd));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    resetn = 1'b0;
    mv = '0; mvf = '0; sr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ma[i] = '0; wd[i] = '0; ws[i] = '0; maf[i] = '0;
    end
    #2;
    chk("rst_s_valid", 64'(s_valid), 64'd0);
    chk("rst_m_ready", 64'(m_ready), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("rst_s_addr", 64'(s_addr), 64'd0);
    chk("rst_s_wdata", 64'(s_wdata), 64'd0);
    chk("rst_s_wstrb", 64'(s_wstrb), 64'd0);
    step(2);
    resetn = 1'b1;

    // Single master, slave ready in the third BUSY cycle
    ma[2] = 32'h100;
    mv = 4'b0100;
    expect_rr(2, 1'b0, 1'b0, 0);
    step(1);
    @(negedge clk);
    chk("t1_s_valid", 64'(s_valid), 64'd1);
    chk("t1_grant_id", 64'(grant_id), 64'd2);
    chk("t1_s_addr", 64'(s_addr), 64'h100);
    chk("t1_no_early_ready", 64'(m_ready), 64'd0);
    step(2);
    sr = 1'b1;
    step(1);
    mv = '0; sr = 1'b0;
    @(negedge clk);
    chk("t1_idle_s_valid", 64'(s_valid), 64'd0);
    chk("t1_idle_s_addr", 64'(s_addr), 64'd0);

    // Round-robin fairness, zero-wait slave
    do_reset();
    for (int i = 0; i < 4; i++) ma[i] = 32'h1000 + 32'(i * 4);
    sr = 1'b1;
    mv = 4'hF;
    expect_rr(0, 1'b0, 1'b0, 0);
    expect_rr(1, 1'b0, 1'b0, 2);
    expect_rr(2, 1'b0, 1'b0, 2);
    expect_rr(3, 1'b0, 1'b0, 2);
    expect_rr(0, 1'b0, 1'b0, 2);
    step(10);
    mv = '0; sr = 1'b0;
    step(1);

    // Fixed priority: master 1 beats master 3 while it stays valid
    maf[1] = 32'h2100;
    maf[3] = 32'h2300;
    mvf = 4'b1010;
    expect_fx(1); expect_fx(1); expect_fx(1);
    step(6);
    mvf = 4'b1000;
    expect_fx(3);
    step(2);
    mvf = '0;
    step(1);

    // Watchdog boundary: s_ready on the expiry cycle is a normal completion
    ma[0] = 32'h3000;
    mv = 4'b0001;
    expect_rr(0, 1'b0, 1'b0, 0);
    step(8);
    sr = 1'b1;
    step(1);
    mv = '0; sr = 1'b0;
    @(negedge clk);
    chk("tb_timeout_err_clear", 64'(timeout_err), 64'd0);

    // Watchdog expiry on the 8th BUSY cycle
    ma[1] = 32'h200;
    mv = 4'b0010;
    expect_rr(1, 1'b1, 1'b0, 0);
    step(8);
    step(1);
    mv = '0;
    @(negedge clk);
    chk("to_timeout_err_set", 64'(timeout_err), 64'd1);
    chk("to_s_valid_after", 64'(s_valid), 64'd0);

    // Following request is served normally, flag stays set
    ma[3] = 32'h300;
    mv = 4'b1000;
    sr = 1'b1;
    expect_rr(3, 1'b0, 1'b1, 0);
    step(2);
    mv = '0; sr = 1'b0;

    // Abort: granted master drops valid before s_ready
    ma[2] = 32'h400;
    mv = 4'b0100;
    step(2);
    mv = '0;
    @(negedge clk);
    chk("ab_s_valid_drop", 64'(s_valid), 64'd0);
    step(1);
    // rr pointer must still be 0, so master 1 beats master 3
    ma[1] = 32'h410;
    ma[3] = 32'h430;
    mv = 4'b1010;
    sr = 1'b1;
    expect_rr(1, 1'b0, 1'b1, 0);
    step(1);
    @(negedge clk);
    chk("ab_next_grant", 64'(grant_id), 64'd1);
    chk("ab_next_ready", 64'(m_ready), 64'b0010);
    step(1);
    mv = '0; sr = 1'b0;
    step(1);

    // Reset asserted during BUSY
    ma[2] = 32'h500;
    mv = 4'b0100;
    step(1);
    chk("rb_busy_s_valid", 64'(s_valid), 64'd1);
    resetn = 1'b0;
    #1;
    chk("rb_s_valid", 64'(s_valid), 64'd0);
    chk("rb_m_ready", 64'(m_ready), 64'd0);
    chk("rb_grant_id", 64'(grant_id), 64'd0);
    chk("rb_s_addr", 64'(s_addr), 64'd0);
    chk("rb_timeout_err", 64'(timeout_err), 64'd0);
    mv = '0;
    step(1);
    resetn = 1'b1;

    // Write path: distinct data per master must reach the slave unmixed
    ma[0] = 32'h600; wd[0] = 32'hAABBCCDD; ws[0] = 4'b0011;
    ma[1] = 32'h610; wd[1] = 32'h11223344; ws[1] = 4'b1111;
    mv = 4'b0011;
    sr = 1'b1;
    expect_rr(0, 1'b0, 1'b0, 0);
    expect_rr(1, 1'b0, 1'b0, 2);
    step(4);
    mv = '0; sr = 1'b0;
    step(3);

    chk("rr_queue_drained", 64'(q_rr.size()), 64'd0);
    chk("fx_queue_drained", 64'(q_fx.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_n.md
Name: bus_arbiter_n

Overview:
- Parametrised N-master to 1-slave arbiter for the valid/ready memory bus used between the vigna core and memory.
- Successor to the fixed two-master mux. Adds parametric master count and bus widths, selectable round-robin or fixed priority, a per-transaction grant lock and a slave-timeout watchdog.
- Sits between the core's instruction/data ports (plus optional DMA/debug masters) and the single system bus.

Parameters:
- NUM_M, 2, number of masters (2..8); master 0 is highest priority in fixed mode.
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8); strobe width is DATA_W/8.
- RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority.
- TIMEOUT, 1024, cycles to wait for s_ready before forced completion; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- m_valid  in  NUM_M  per-master request.
- m_ready  out  NUM_M  per-master completion pulse.
- m_addr  in  NUM_M*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W].
- m_wdata  in  NUM_M*DATA_W  packed write data.
- m_wstrb  in  NUM_M*DATA_W/8  packed strobes; all-zero means read.
- m_rdata  out  DATA_W  shared read data, valid only with the m_ready bit set.
- s_valid  out  1  slave request.
- s_ready  in  1  slave completion.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_wstrb  out  DATA_W/8  slave strobes.
- s_rdata  in  DATA_W  slave read data.
- grant_id  out  clog2(NUM_M) (min 1)  currently or last granted master.
- timeout_err  out  1  sticky flag; set on watchdog expiry, cleared only by reset.

Behaviour:
- Reset (async, resetn=0): state=IDLE; grant_id=0; rr pointer=0; counter=0; timeout_err=0. All outputs 0: s_valid, m_ready, s_addr/s_wdata/s_wstrb.
- States:
  - IDLE: if any m_valid, pick a winner combinationally. Register grant_id=winner and go to BUSY. Counter cleared. No s_valid in IDLE.
  - BUSY:
    - s_valid = m_valid[grant_id]; s_addr/s_wdata/s_wstrb = granted master's fields; m_rdata = s_rdata.
    - s_ready=1: m_ready[grant_id]=1 the same cycle (combinational), then go to IDLE.
    - m_valid[grant_id] drops before s_ready (protocol abort): go to IDLE next cycle with no m_ready.
    - Counter reaches TIMEOUT-1 with s_ready low (TIMEOUT>0): m_ready[grant_id]=1 with m_rdata=0, timeout_err<=1, go to IDLE. s_valid is deasserted from the following cycle.
- Latency: request in IDLE, s_valid visible in the next cycle. Minimum of 2 cycles per transaction, with one IDLE bubble between back-to-back grants.
- Round-robin: search starts at rr pointer, wraps modulo NUM_M. On every completion (normal or timeout) rr pointer <= grant_id+1, wrapping NUM_M-1 to 0. Aborts do not advance it.
- Fixed priority: lowest index with m_valid wins. The rr pointer is unused.
- Grant is locked for the whole transaction. New requests from other masters never change grant_id while BUSY.
- At most one m_ready bit is high in any cycle. m_ready is never high in IDLE.
- s_ready arriving on the same cycle as the watchdog expiry: normal completion wins and timeout_err is unchanged.
- Outputs when not BUSY: s_addr/s_wdata/s_wstrb are driven to 0.

Decomposition:
- Shared package: localparams for state encoding (IDLE=0, BUSY=1), GRANT_W = clog2(NUM_M) with a minimum of 1, and the strobe width.
- One natural sub-module, rr_picker: combinational one-hot/index winner from a request vector and start pointer, with a mode input for fixed priority. It is reusable by future interconnect.

Test Plan:
- Single master: NUM_M=4, m_valid=0100, addr 0x100, slave ready after 3 cycles. Expect grant_id=2, s_addr=0x100, s_valid in cycle 1, m_ready=0100 for exactly 1 cycle, then IDLE.
- Round-robin fairness: RR_EN=1, all four masters continuously valid, zero-wait slave. Expect grant order 0,1,2,3,0 and each m_ready pulse 2 cycles apart.
- Fixed priority: RR_EN=0, masters 1 and 3 valid. Expect master 1 served repeatedly while it stays valid; master 3 is served only after m_valid[1]=0.
- Timeout: TIMEOUT=8, s_ready held 0. Expect m_ready pulse with m_rdata=0 on the 8th BUSY cycle, timeout_err=1 and sticky. A following request is served normally.
- Abort and reset: the granted master drops valid mid-transaction. Expect no m_ready and IDLE the next cycle. Then assert resetn=0 during BUSY: all outputs 0 immediately, grant_id=0.
- Write path: master 0 sends wstrb=0011, wdata=0xAABBCCDD. Expect s_wstrb=0011, s_wdata=0xAABBCCDD, and the same data is not visible to other masters' m_ready.
